// File: rtl/freq_result_queue.sv
// Frame-result FIFO behind the spectral analysis stage: tags each dominant-bin
// index with a frame sequence number, buffers it, and tracks bin stability.
module freq_result_queue #(
    parameter int DEPTH    = 8,
    parameter int STABLE_N = 4,
    parameter int FCNT_W   = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [3:0]        in_freq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_freq,
    output logic [FCNT_W-1:0] out_frame,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              stable,
    output logic [3:0]        stable_freq
);

    typedef struct packed {
        logic [FCNT_W-1:0] frame;
        logic [3:0]        freq;
    } entry_t;

    localparam logic [3:0] SN = 4'(STABLE_N);

    entry_t            mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] frame_cnt;
    logic [3:0]        run_len, run_nxt;
    logic              full, pop, push;
    entry_t            head;

    assign level     = wr_ptr - rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = in_valid & (~full | pop);

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_freq  = out_valid ? head.freq  : '0;
    assign out_frame = out_valid ? head.frame : '0;

    // Storage is not reset; everything read from it is qualified by out_valid.
    always_ff @(posedge clk) begin
        if (!clear && push)
            mem[wr_ptr[AW-1:0]] <= '{frame: frame_cnt, freq: in_freq};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Counter advances on dropped frames too so gaps expose the loss.
            if (in_valid)
                frame_cnt <= frame_cnt + 1'b1;
            if (in_valid && !push)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        run_nxt = run_len;
        if (run_len == 4'd0 || in_freq != stable_freq)
            run_nxt = 4'd1;
        else if (run_len >= SN)
            run_nxt = SN;
        else
            run_nxt = run_len + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len     <= '0;
            stable      <= 1'b0;
            stable_freq <= '0;
        end else if (clear) begin
            run_len     <= '0;
            stable      <= 1'b0;
            stable_freq <= '0;
        end else if (in_valid) begin
            run_len     <= run_nxt;
            stable      <= (run_nxt == SN);
            stable_freq <= in_freq;
        end
    end

endmodule

// File: tb/tb_freq_result_queue.sv
// Directed bench for freq_result_queue: vector table plus hand sequences for
// fill/overflow, full push+pop, frame wrap, clear and asynchronous reset.
module tb_freq_result_queue;

    localparam int DEPTH = 8, STABLE_N = 4, FCNT_W = 8, AW = 3;

    logic              clk, rst, clear, in_valid, out_ready;
    logic [3:0]        in_freq;
    logic              out_valid, overflow, stable;
    logic [3:0]        out_freq, stable_freq;
    logic [FCNT_W-1:0] out_frame;
    logic [AW:0]       level;

    int checks = 0;
    int errors = 0;

    freq_result_queue #(.DEPTH(DEPTH), .STABLE_N(STABLE_N), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_freq(in_freq),
        .out_valid(out_valid), .out_ready(out_ready), .out_freq(out_freq),
        .out_frame(out_frame), .level(level), .overflow(overflow),
        .stable(stable), .stable_freq(stable_freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [3:0] f; logic rdy; logic clr;
        logic ev; logic [3:0] efreq; int eframe; int elevel;
        logic eovf; logic estab; logic [3:0] esf;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic drive(input logic iv, input logic [3:0] f, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid = iv; in_freq = f; out_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input int fr, input int fq, input int lv);
        chk({name, ".out_valid"}, int'(out_valid), 1);
        chk({name, ".out_frame"}, int'(out_frame), fr);
        chk({name, ".out_freq"}, int'(out_freq), fq);
        chk({name, ".level"}, int'(level), lv);
    endtask

    initial begin
        //        iv f  rdy clr  ev freq frame lvl ovf stab sf
        vecs[0]  = '{1, 5, 0, 0,  1, 5, 0, 1, 0, 0, 5};
        vecs[1]  = '{0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 5};
        vecs[2]  = '{1, 7, 0, 0,  1, 7, 1, 1, 0, 0, 7};
        vecs[3]  = '{1, 7, 0, 0,  1, 7, 1, 2, 0, 0, 7};
        vecs[4]  = '{1, 7, 0, 0,  1, 7, 1, 3, 0, 0, 7};
        vecs[5]  = '{1, 7, 0, 0,  1, 7, 1, 4, 0, 1, 7};
        vecs[6]  = '{1, 7, 0, 0,  1, 7, 1, 5, 0, 1, 7};
        vecs[7]  = '{1, 2, 1, 0,  1, 7, 2, 5, 0, 0, 2};
        vecs[8]  = '{0, 0, 1, 0,  1, 7, 3, 4, 0, 0, 2};
        vecs[9]  = '{1, 9, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 4, 0, 0,  1, 4, 0, 1, 0, 0, 4};
        vecs[11] = '{0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 4};
        vecs[12] = '{0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 4};

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_freq = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle.out_valid", int'(out_valid), 0);
            chk("idle.level", int'(level), 0);
            chk("idle.overflow", int'(overflow), 0);
            chk("idle.stable", int'(stable), 0);
            chk("idle.out_frame", int'(out_frame), 0);
        end

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].iv, vecs[i].f, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d.out_freq", i), int'(out_freq), int'(vecs[i].efreq));
            chk($sformatf("vec%0d.out_frame", i), int'(out_frame), vecs[i].eframe);
            chk($sformatf("vec%0d.level", i), int'(level), vecs[i].elevel);
            chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].eovf));
            chk($sformatf("vec%0d.stable", i), int'(stable), int'(vecs[i].estab));
            chk($sformatf("vec%0d.stable_freq", i), int'(stable_freq), int'(vecs[i].esf));
        end

        // Fill past capacity with the host stalled, then drain in order.
        drive(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) drive(1, 4'(i), 0, 0);
        chk_head("fill", 0, 0, 8);
        chk("fill.overflow", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk_head($sformatf("drain%0d", i), i, i, 8 - i);
            drive(0, 0, 1, 0);
        end
        chk("drain.level", int'(level), 0);
        chk("drain.out_valid", int'(out_valid), 0);
        drive(1, 4'd11, 0, 0);
        chk_head("after_drop", 10, 11, 1);
        chk("after_drop.overflow", int'(overflow), 1);

        // Full FIFO with simultaneous push and pop keeps level at DEPTH.
        drive(0, 0, 0, 1);
        chk("clr.overflow", int'(overflow), 0);
        for (int i = 0; i < 8; i++) drive(1, 4'(i), 0, 0);
        chk_head("full", 0, 0, 8);
        for (int k = 0; k < 5; k++) begin
            drive(1, 4'd3, 1, 0);
            chk_head($sformatf("fullpp%0d", k), k + 1, k + 1, 8);
            chk($sformatf("fullpp%0d.overflow", k), int'(overflow), 0);
        end
        for (int j = 0; j < 8; j++) begin
            chk_head($sformatf("ppdrain%0d", j), 5 + j, (j < 3) ? 5 + j : 3, 8 - j);
            drive(0, 0, 1, 0);
        end
        chk("ppdrain.level", int'(level), 0);

        // Frame counter wrap under continuous drain.
        drive(0, 0, 0, 1);
        for (int i = 0; i < 258; i++) begin
            drive(1, 4'(i % 16), 1, 0);
            chk_head($sformatf("wrap%0d", i), i % 256, i % 16, 1);
        end
        drive(1, 4'd6, 1, 1);
        chk("clrpush.level", int'(level), 0);
        chk("clrpush.overflow", int'(overflow), 0);
        chk("clrpush.stable_freq", int'(stable_freq), 0);
        drive(1, 4'd9, 0, 0);
        chk_head("postclr", 0, 9, 1);

        // Asynchronous reset mid-cycle discards stored entries immediately.
        drive(1, 4'd9, 0, 0);
        drive(1, 4'd9, 0, 0);
        chk("prerst.level", int'(level), 3);
        #2 rst = 1'b0;
        #1;
        chk("asyncrst.level", int'(level), 0);
        chk("asyncrst.out_valid", int'(out_valid), 0);
        chk("asyncrst.stable_freq", int'(stable_freq), 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        @(negedge clk) rst = 1'b1;
        drive(1, 4'd1, 0, 0);
        chk_head("postrst", 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
